tuning_word_normalizer: RTL and testbench



---
 rtl/tuning_word_normalizer_pkg.sv | 21 ++
 rtl/tuning_word_normalizer.sv | 70 +++++++
 tb/tb_tuning_word_normalizer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/tuning_word_normalizer_pkg.sv
// Shared definitions for the tuning-word normaliser: FSM encoding, default
// geometry and the top-bits zero test used by the shift loop.
package tuning_word_normalizer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEF_W         = 40;
  localparam int DEF_TOP       = 12;
  localparam int DEF_SHW       = 4;
  localparam int DEF_MAX_SHIFT = 12;
  localparam int DEF_BASE_DIV  = 12;

  // Word is zero-extended to 64 bits, so anything above w is already clear.
  function automatic logic top_clear(input logic [63:0] word, input int w, input int top);
    return ((word >> (w - top)) == 64'd0);
  endfunction

endpackage

// File: rtl/tuning_word_normalizer.sv
// Normalises a tuning word by right-shifting until its TOP MSBs are clear and
// reports the shift count plus the derived clock-divider select.
module tuning_word_normalizer
  import tuning_word_normalizer_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int TOP       = DEF_TOP,
  parameter int SHW       = DEF_SHW,
  parameter int MAX_SHIFT = DEF_MAX_SHIFT,
  parameter int BASE_DIV  = DEF_BASE_DIV
) (
  input  logic           CLK67MHZ,
  input  logic           resetPort,
  input  logic [W-1:0]   in_word,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   out_word,
  output logic [SHW-1:0] out_shift,
  output logic [SHW-1:0] out_div,
  output logic           out_sat,
  output logic           out_valid,
  output logic           busy
);

  localparam logic [SHW-1:0] MAX_CNT  = SHW'(MAX_SHIFT);
  localparam logic [SHW-1:0] BASE_SEL = SHW'(BASE_DIV);

  state_t         state;
  logic [W-1:0]   work;
  logic [SHW-1:0] cnt;
  logic           accept;
  logic           clear;

  // Both states accept new work; a new word simply restarts the job.
  assign in_ready = !resetPort && (state == IDLE || state == SHIFT);
  assign busy     = (state == SHIFT);
  assign accept   = in_valid && in_ready;
  assign clear    = top_clear(64'(work), W, TOP);

  always_ff @(posedge CLK67MHZ) begin
    out_valid <= 1'b0;
    if (resetPort) begin
      state     <= IDLE;
      work      <= '0;
      cnt       <= '0;
      out_word  <= '0;
      out_shift <= '0;
      out_div   <= BASE_SEL;
      out_sat   <= 1'b0;
    end else if (accept) begin
      work  <= in_word;
      cnt   <= '0;
      state <= SHIFT;
    end else if (state == SHIFT) begin
      if (clear || cnt == MAX_CNT) begin
        // All result fields move together so downstream never sees a mix.
        out_word  <= work;
        out_shift <= cnt;
        out_div   <= BASE_SEL - cnt;
        out_sat   <= !clear;
        out_valid <= 1'b1;
        state     <= IDLE;
      end else begin
        work <= work >> 1;
        cnt  <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tuning_word_normalizer.sv
// Bench for tuning_word_normalizer: default instance plus a MAX_SHIFT=8 one,
// directed cases followed by randomised words against a leading-one model.
module tb_tuning_word_normalizer;

  localparam int W = 40;

  logic          CLK67MHZ = 1'b0;
  logic          resetPort;
  logic [W-1:0]  in_word;
  logic          in_valid_a, in_valid_b;

  logic          ir_a, ov_a, sat_a, busy_a;
  logic [W-1:0]  ow_a;
  logic [3:0]    os_a, od_a;
  logic          ir_b, ov_b, sat_b, busy_b;
  logic [W-1:0]  ow_b;
  logic [3:0]    os_b, od_b;

  int checks = 0;
  int errors = 0;

  always #5 CLK67MHZ = ~CLK67MHZ;

  tuning_word_normalizer dut_a (
    .CLK67MHZ(CLK67MHZ), .resetPort(resetPort), .in_word(in_word),
    .in_valid(in_valid_a), .in_ready(ir_a), .out_word(ow_a), .out_shift(os_a),
    .out_div(od_a), .out_sat(sat_a), .out_valid(ov_a), .busy(busy_a)
  );

  tuning_word_normalizer #(.MAX_SHIFT(8)) dut_b (
    .CLK67MHZ(CLK67MHZ), .resetPort(resetPort), .in_word(in_word),
    .in_valid(in_valid_b), .in_ready(ir_b), .out_word(ow_b), .out_shift(os_b),
    .out_div(od_b), .out_sat(sat_b), .out_valid(ov_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: shifts needed = how far the leading one sits above bit W-TOP-1,
  // clamped to the shift limit (saturating only when the clamp bites).
  task automatic model(input logic [W-1:0] w, input int maxs,
                       output logic [W-1:0] mw, output int ms, output int mdiv,
                       output bit msat);
    int p;
    int need;
    p = -1;
    for (int i = 0; i < W; i++) if (w[i]) p = i;
    need = (p > W - 12 - 1) ? p - (W - 12 - 1) : 0;
    msat = (need > maxs);
    ms   = msat ? maxs : need;
    mw   = w >> ms;
    mdiv = 12 - ms;
  endtask

  task automatic run_job(input bit sel, input logic [W-1:0] w, input string tag);
    logic [W-1:0] mw, cw;
    int ms, mdiv, found, nval;
    bit msat;
    logic [3:0] cs, cd;
    logic csat, v;
    model(w, sel ? 8 : 12, mw, ms, mdiv, msat);
    found = -1; nval = 0;
    cw = '0; cs = '0; cd = '0; csat = 1'b0;
    @(negedge CLK67MHZ);
    in_word = w;
    if (sel) in_valid_b = 1'b1; else in_valid_a = 1'b1;
    @(posedge CLK67MHZ);
    #1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK67MHZ);
      v = sel ? ov_b : ov_a;
      if (v) begin
        nval++;
        if (found < 0) begin
          found = k;
          cw = sel ? ow_b : ow_a;
          cs = sel ? os_b : os_a;
          cd = sel ? od_b : od_a;
          csat = sel ? sat_b : sat_a;
        end
      end
    end
    chk({tag, " latency"}, 64'(found), 64'(ms + 2));
    chk({tag, " strobes"}, 64'(nval), 64'd1);
    chk({tag, " word"}, 64'(cw), 64'(mw));
    chk({tag, " shift"}, 64'(cs), 64'(ms));
    chk({tag, " div"}, 64'(cd), 64'(mdiv));
    chk({tag, " sat"}, 64'(csat), 64'(msat));
    chk({tag, " hold"}, 64'(sel ? ow_b : ow_a), 64'(mw));
  endtask

  initial begin
    int nval, found;
    logic [W-1:0] rw;
    bit rsel;
    resetPort  = 1'b1;
    in_word    = '0;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    repeat (3) @(posedge CLK67MHZ);
    @(negedge CLK67MHZ);
    chk("rst ready", 64'(ir_a), 64'd0);
    chk("rst word", 64'(ow_a), 64'd0);
    chk("rst shift", 64'(os_a), 64'd0);
    chk("rst div", 64'(od_a), 64'd12);
    chk("rst sat", 64'(sat_a), 64'd0);
    chk("rst valid", 64'(ov_a), 64'd0);
    chk("rst busy", 64'(busy_a), 64'd0);
    chk("rst div b", 64'(od_b), 64'd12);
    resetPort = 1'b0;
    #1 chk("ready after rst", 64'(ir_a), 64'd1);

    run_job(1'b0, 40'h00_0000_1234, "no shift");
    run_job(1'b0, 40'hFF_FFFF_FFFF, "full 12");
    run_job(1'b1, 40'hFF_FFFF_FFFF, "sat 8");
    run_job(1'b0, 40'h00_0000_0000, "zero");
    run_job(1'b0, 40'h01_0000_0000, "five");

    // Abort: second word in cycle 4 replaces the long job.
    nval = 0; found = -1;
    @(negedge CLK67MHZ);
    in_word = 40'hFF_FFFF_FFFF;
    in_valid_a = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge CLK67MHZ);
      if (ov_a) begin
        nval++;
        if (found < 0) begin
          found = c;
          chk("abort word", 64'(ow_a), 64'd1);
          chk("abort shift", 64'(os_a), 64'd0);
        end
      end
      in_valid_a = (c == 4);
      if (c == 4) in_word = 40'h00_0000_0001;
    end
    chk("abort cycle", 64'(found), 64'd6);
    chk("abort strobes", 64'(nval), 64'd1);

    // Reset in cycle 3 of a 12-shift job; in_valid during reset is ignored.
    run_job(1'b0, 40'h01_0000_0000, "pre rst");
    @(negedge CLK67MHZ);
    in_word = 40'hFF_FFFF_FFFF;
    in_valid_a = 1'b1;
    @(posedge CLK67MHZ);
    #1 in_valid_a = 1'b0;
    repeat (2) @(posedge CLK67MHZ);
    @(negedge CLK67MHZ);
    resetPort = 1'b1;
    in_word = 40'h00_0000_0001;
    in_valid_a = 1'b1;
    #1 chk("ready in rst", 64'(ir_a), 64'd0);
    @(posedge CLK67MHZ);
    #1 in_valid_a = 1'b0;
    @(negedge CLK67MHZ);
    chk("mid rst busy", 64'(busy_a), 64'd0);
    chk("mid rst word", 64'(ow_a), 64'd0);
    chk("mid rst shift", 64'(os_a), 64'd0);
    chk("mid rst div", 64'(od_a), 64'd12);
    chk("mid rst sat", 64'(sat_a), 64'd0);
    resetPort = 1'b0;
    nval = 0;
    for (int c = 0; c < 16; c++) begin
      if (ov_a || busy_a) nval++;
      @(negedge CLK67MHZ);
    end
    chk("no strobe after rst", 64'(nval), 64'd0);
    run_job(1'b0, 40'h00_0000_0000, "post rst zero");

    for (int i = 0; i < 24; i++) begin
      rsel = 1'($urandom_range(0, 1));
      rw = {8'($urandom), 32'($urandom)};
      rw = rw >> $urandom_range(0, 40);
      run_job(rsel, rw, rsel ? "rand b" : "rand a");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
